// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
//   Items shared by the input conditioner and the logic around it:
//   - bit positions of the compass buttons on the input bus
//   - default timing values for the 33 MHz board clock
//   - clog2_f, a ceiling-log2 helper that never returns less than 1
package input_conditioner_pkg;

  // Bit positions of the compass buttons on the conditioner bus
  localparam int B_CENTER = 0;
  localparam int B_EAST   = 1;
  localparam int B_NORTH  = 2;
  localparam int B_SOUTH  = 3;
  localparam int B_WEST   = 4;

  // Default timing for CLK_33MHZ_FPGA
  localparam int WIDTH_DEF            = 7;
  localparam int SYNC_STAGES_DEF      = 2;
  localparam int SAMPLE_COUNT_MAX_DEF = 25_080;  // 0.76 ms sample interval
  localparam int PULSE_COUNT_MAX_DEF  = 150;     // samples to accept a new level
  localparam int REPEAT_DELAY_DEF     = 658;     // ~0.5 s before the first repeat
  localparam int REPEAT_PERIOD_DEF    = 132;     // ~0.1 s between repeats

  // Ceiling log2, clamped to at least 1 so it can size a counter holding 0
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/conditioner_channel.sv
// conditioner_channel
//   Handles one input bit: a synchronizer, a symmetric debouncer, registered
//   press/release edge pulses, and optional hold-to-repeat.
//   The repeat feature is built only when INPUT_CONDITIONER_REPEAT_EN is
//   defined.
// Ports:
//   clk       : system clock
//   reset_b   : asynchronous active-low reset
//   tick_i    : shared sample strobe, one cycle wide
//   in_i      : raw asynchronous pin level
//   level_o   : debounced level
//   press_o   : one-cycle pulse when level_o first reads 1 (and on repeats)
//   release_o : one-cycle pulse when level_o first reads 0
module conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int PULSE_COUNT_MAX = 150,
  parameter int REPEAT_DELAY    = 658,
  parameter int REPEAT_PERIOD   = 132
) (
  input  logic clk,
  input  logic reset_b,
  input  logic tick_i,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DW = clog2_f(PULSE_COUNT_MAX + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(PULSE_COUNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   rise, fall, rep_fire;

  // Synchronizer chain; the oldest stage feeds the debouncer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end
  assign s = sync_q[SYNC_STAGES-1];

  // Debouncer. Any cycle where the input agrees with the level clears the
  // count, so even a one-cycle glitch restarts the whole debounce.
  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == DCNT_LAST) begin
        level_d = ~level_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign rise =  level_d & ~level_q;
  assign fall = ~level_d &  level_q;

`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = clog2_f(REP_MAX + 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rphase_q, rphase_d;  // 0: waiting out the delay, 1: periodic

  // The counter runs only while the level stays high across the edge.
  // The rising cycle (level_q==0) and the release cycle (level_d==0) both
  // clear it, so a release never coincides with a repeat.
  always_comb begin
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    rep_fire = 1'b0;
    if (!(level_q && level_d)) begin
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end else if (tick_i) begin
      if (!rphase_q && (rcnt_q == RW'(REPEAT_DELAY - 1))) begin
        rep_fire = 1'b1;
        rcnt_d   = '0;
        rphase_d = 1'b1;
      end else if (rphase_q && (rcnt_q == RW'(REPEAT_PERIOD - 1))) begin
        rep_fire = 1'b1;
        rcnt_d   = '0;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Pulses are registered on the same edge as the level, so they line up
  // with the level change with no extra cycle.
  assign press_d   = rise | rep_fire;
  assign release_d = fall;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   An N-channel front end for the mechanical board inputs. One shared
//   sample-tick generator drives WIDTH independent conditioner_channel
//   instances. Defining INPUT_CONDITIONER_REPEAT_EN adds hold-to-repeat
//   press pulses.
// Ports:
//   clk       : system clock (CLK_33MHZ_FPGA)
//   reset_b   : asynchronous active-low reset
//   in_i      : raw pin levels, active-high, [WIDTH]
//   level_o   : debounced levels, [WIDTH]
//   press_o   : one-cycle press pulses, [WIDTH]
//   release_o : one-cycle release pulses, [WIDTH]
//   The data ports carry _i/_o suffixes. Without a suffix the release output
//   would clash with a reserved word of the language.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH            = WIDTH_DEF,
  parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
  parameter int SAMPLE_COUNT_MAX = SAMPLE_COUNT_MAX_DEF,
  parameter int PULSE_COUNT_MAX  = PULSE_COUNT_MAX_DEF,
  parameter int REPEAT_DELAY     = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD    = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o
);

  localparam int CW = clog2_f(SAMPLE_COUNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_COUNT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  // Shared sample counter: counts 0..SAMPLE_COUNT_MAX-1 and wraps. The tick
  // is the wrap cycle.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_b   (reset_b),
      .tick_i    (tick),
      .in_i      (in_i[g]),
      .level_o   (level_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Randomized and directed stimulus for input_conditioner. A reference model
//   works out when each debounced level should change from edge counts and
//   sample-tick arithmetic, and queues the expected pulses. A monitor
//   compares them with the DUT outputs.
//   Define INPUT_CONDITIONER_REPEAT_EN for both RTL and bench to cover the
//   hold-to-repeat feature.
module tb_input_conditioner;
  localparam int W   = 3;
  localparam int SS  = 2;
  localparam int SCM = 4;
  localparam int PCM = 3;
  localparam int RD  = 5;
  localparam int RP  = 2;
  localparam int EW  = 32 + 2 * W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic [W-1:0] in_i = '0;
  logic [W-1:0] level_o, press_o, release_o;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH            (W),
    .SYNC_STAGES      (SS),
    .SAMPLE_COUNT_MAX (SCM),
    .PULSE_COUNT_MAX  (PCM),
    .REPEAT_DELAY     (RD),
    .REPEAT_PERIOD    (RP)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .in_i      (in_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // k counts clock edges since reset release. The sample counter starts at 0,
  // so edge k sees a tick exactly when k is a multiple of SCM. The level
  // flips once PCM ticks have passed since the last edge where the
  // synchronized input agreed with it.
  int           k;
  logic [W-1:0] m_level;
  int           m_agree [W];
  int           m_press_at [W];
  logic [W-1:0] hist [$];
  logic [EW-1:0] exp_q [$];   // {edge, press, release}

  function automatic int ticks_in(input int a, input int b);
    return (b / SCM) - (a / SCM);   // ticks on edges a+1..b
  endfunction

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      k = 0;
      m_level = '0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back('0);
      for (int c = 0; c < W; c++) begin
        m_agree[c] = 0;
        m_press_at[c] = 0;
      end
    end else begin
      logic [W-1:0] s_pre, np, nr;
      logic         tk, old;
      int           t;
      k++;
      hist.push_back(in_i);
      s_pre = hist.pop_front();
      tk = (k % SCM) == 0;
      np = '0;
      nr = '0;
      for (int c = 0; c < W; c++) begin
        old = m_level[c];
        if (s_pre[c] == m_level[c]) begin
          m_agree[c] = k;
        end else if (tk && ticks_in(m_agree[c], k) == PCM) begin
          m_level[c] = ~m_level[c];
          m_agree[c] = k;
          if (m_level[c]) begin
            np[c] = 1'b1;
            m_press_at[c] = k;
          end else begin
            nr[c] = 1'b1;
          end
        end
`ifdef INPUT_CONDITIONER_REPEAT_EN
        if (old && m_level[c] && tk) begin
          t = ticks_in(m_press_at[c], k);
          if (t == RD || (t > RD && ((t - RD) % RP) == 0)) np[c] = 1'b1;
        end
`else
        t = 0;
        if (old && t != 0) np[c] = 1'b1;
`endif
      end
      if ((np | nr) != '0) exp_q.push_back({k[31:0], np, nr});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int press_cnt [W];
  int rel_cnt [W];
  int first_press_k [W];
  int first_rel_k [W];
  int press_k0 [$];

  always @(negedge clk) begin
    if (reset_b) begin
      logic [EW-1:0] e;
      check("level", 32'(level_o), 32'(m_level));
      if (exp_q.size() > 0 && exp_q[0][EW-1:2*W] == k[31:0]) begin
        e = exp_q.pop_front();
        check("pulses", 32'({press_o, release_o}), 32'(e[2*W-1:0]));
      end else if ((press_o | release_o) != '0) begin
        check("unexpected_pulse", 32'({press_o, release_o}), 32'd0);
      end
      for (int c = 0; c < W; c++) begin
        if (press_o[c]) begin
          if (press_cnt[c] == 0) first_press_k[c] = k;
          press_cnt[c]++;
          if (c == 0) press_k0.push_back(k);
        end
        if (release_o[c]) begin
          if (rel_cnt[c] == 0) first_rel_k[c] = k;
          rel_cnt[c]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < W; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c] = 0;
      first_press_k[c] = 0;
      first_rel_k[c] = 0;
    end
    press_k0.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int kd;
    int lat;
    clear_counts();

    // Reset held with all inputs high
    in_i = 3'b111;
    reset_b = 1'b0;
    cycles(3);
    check("reset_level", 32'(level_o), 32'd0);
    check("reset_press", 32'(press_o), 32'd0);
    check("reset_release", 32'(release_o), 32'd0);
    reset_b = 1'b1;
    cycles(14);
    check("post_reset_level", 32'(level_o), 32'b111);
    cycles(2);
    for (int c = 0; c < W; c++) check($sformatf("post_reset_press_cnt%0d", c), 32'(press_cnt[c]), 32'd1);

    // Drop all inputs, then a clean step on in[0]
    in_i = '0;
    cycles(20);
    clear_counts();
    in_i[0] = 1'b1;
    kd = k;
    cycles(40);
    lat = first_press_k[0] - kd;
    check("step_press_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
`ifndef INPUT_CONDITIONER_REPEAT_EN
    check("step_press_count", 32'(press_cnt[0]), 32'd1);
`endif
    in_i[0] = 1'b0;
    kd = k;
    cycles(20);
    lat = first_rel_k[0] - kd;
    check("step_release_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
    check("step_release_count", 32'(rel_cnt[0]), 32'd1);

    // Glitch on in[1]: high 6, low 1, high 30
    clear_counts();
    in_i[1] = 1'b1;
    cycles(6);
    in_i[1] = 1'b0;
    cycles(1);
    in_i[1] = 1'b1;
    kd = k;
    cycles(30);
    check("glitch_press_seen", 32'(press_cnt[1] >= 1), 32'd1);
    check("glitch_restart_latency", 32'(first_press_k[1] - kd >= 11), 32'd1);
`ifndef INPUT_CONDITIONER_REPEAT_EN
    check("glitch_press_count", 32'(press_cnt[1]), 32'd1);
`endif
    check("glitch_release_count", 32'(rel_cnt[1]), 32'd0);

    // Simultaneous: in[0] rises while in[2] falls
    in_i = 3'b100;
    cycles(25);
    clear_counts();
    in_i = 3'b001;
    cycles(20);
    check("simul_press0", 32'(press_cnt[0] >= 1), 32'd1);
    check("simul_release2", 32'(rel_cnt[2]), 32'd1);
    check("simul_same_edge", 32'(first_press_k[0]), 32'(first_rel_k[2]));
    check("simul_ch1_quiet", 32'(press_cnt[1] + rel_cnt[1]), 32'd0);
    check("simul_no_release0", 32'(rel_cnt[0]), 32'd0);
    check("simul_no_press2", 32'(press_cnt[2]), 32'd0);

    // Mid-operation reset with level[0] high
    check("pre_reset_level0", 32'(level_o[0]), 32'd1);
    clear_counts();
    #2;
    reset_b = 1'b0;
    #1;
    check("async_reset_level", 32'(level_o), 32'd0);
    check("async_reset_release", 32'(release_o), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    cycles(16);
    check("fresh_press_after_reset", 32'(press_cnt[0]), 32'd1);
    check("no_release_after_reset", 32'(rel_cnt[0]), 32'd0);

    // Hold in[0] for 60 cycles
    in_i = '0;
    cycles(20);
    clear_counts();
    in_i[0] = 1'b1;
    cycles(60);
    in_i[0] = 1'b0;
    cycles(20);
`ifdef INPUT_CONDITIONER_REPEAT_EN
    check("repeat_count_ge3", 32'(press_k0.size() >= 3), 32'd1);
    if (press_k0.size() >= 3) begin
      check("repeat_first_gap", 32'(press_k0[1] - press_k0[0]), 32'(RD * SCM));
      check("repeat_period_gap", 32'(press_k0[2] - press_k0[1]), 32'(RP * SCM));
    end
`else
    check("hold_single_press", 32'(press_cnt[0]), 32'd1);
`endif
    check("hold_release", 32'(rel_cnt[0]), 32'd1);

    // Randomized traffic, with the model checking every cycle
    for (int it = 0; it < 200; it++) begin
      in_i = W'($urandom_range(0, (1 << W) - 1));
      cycles($urandom_range(1, 20));
    end
    in_i = '0;
    cycles(30);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised N-channel front end for the board's mechanical inputs: compass buttons, rotary push and CPU reset. Each channel has its own synchronizer, a symmetric debouncer and an edge detector. Channels produce a clean level plus one-cycle press and release pulses. The block sits between the raw board pins and the piano FSM / AC97 controller, and adds optional hold-to-repeat for menu-style controls.

## Interface

Parameters:
- WIDTH, 7: number of independent input channels.
- SYNC_STAGES, 2: synchronizer flops per channel; minimum 2.
- SAMPLE_COUNT_MAX, 25_080: clk cycles per sample tick (0.76 ms at 33 MHz); minimum 1.
- PULSE_COUNT_MAX, 150: consecutive disagreeing samples needed to change the debounced level; minimum 1.
- REPEAT_DELAY, 658: sample ticks a level must be held before the first repeat press (≈0.5 s).
- REPEAT_PERIOD, 132: sample ticks between subsequent repeat presses (≈0.1 s).

Ports:
- clk, input, 1: system clock (CLK_33MHZ_FPGA domain).
- reset_b, input, 1: asynchronous, active-low reset.
- in, input, WIDTH: raw asynchronous pin levels, active-high.
- level, output, WIDTH: debounced level.
- press, output, WIDTH: one-cycle pulse on each debounced rising edge, and on repeats when enabled.
- release, output, WIDTH: one-cycle pulse on each debounced falling edge.

## Operation

- Synchronizer: a SYNC_STAGES-deep flop chain per channel; its last stage is s[i].
- Tick generator: one shared counter runs 0..SAMPLE_COUNT_MAX-1 and wraps. tick=1 for the single cycle where count==SAMPLE_COUNT_MAX-1.
- Debouncer, per channel: counter dcnt, width $clog2(PULSE_COUNT_MAX+1).
  - Any cycle with s[i]==level[i]: dcnt cleared to 0, regardless of tick.
  - On tick with s[i]!=level[i]: dcnt increments.
  - When the increment would reach PULSE_COUNT_MAX: level[i] toggles and dcnt clears, in the same edge.
  - Debounce is symmetric: falling edges need PULSE_COUNT_MAX stable-low samples, exactly as rising edges need stable-high samples.
- Edge outputs are registered:
  - press[i]=1 for exactly the first cycle level[i] reads 1.
  - release[i]=1 for exactly the first cycle level[i] reads 0.
  - press and release never assert together on one channel.
- Channels are fully independent. Any combination of press/release bits may assert in the same cycle.
- Reset (reset_b low, any time): all synchronizer flops, counters, level, press and release go to 0 immediately.
  - No release pulse is generated for a channel that was high when reset hit.
  - A channel held high through reset deassertion yields a normal press after debounce.

## Timing

- Reset values: level=0, press=0, release=0, tick counter=0, all dcnt=0.
- Latency from a clean input step to the level change:
  - minimum SYNC_STAGES + (PULSE_COUNT_MAX-1)·SAMPLE_COUNT_MAX + 1 cycles;
  - maximum adds SAMPLE_COUNT_MAX-1 cycles of tick phase.
- press/release are coincident with the level change, with zero extra cycles.
- A glitch shorter than one sample interval during a count resets dcnt and restarts the full debounce.

## Configuration

- INPUT_CONDITIONER_REPEAT_EN defined:
  - Each channel gets a repeat counter in sample ticks, cleared whenever level[i]==0 and on the press edge.
  - While level[i]==1, a press pulse is issued after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks after that.
  - Repeat pulses are one cycle, aligned to the cycle after the tick.
  - Release clears the repeat state immediately; no repeat pulse occurs in the release cycle.
- Macro undefined: there is no repeat logic, and exactly one press per debounced rising edge.

## Structure

- Shared package input_conditioner_pkg:
  - compass bit index constants (B_CENTER=0, B_EAST=1, B_NORTH=2, B_SOUTH=3, B_WEST=4);
  - default timing constants for 33 MHz;
  - a clog2 helper.
- One sub-module, conditioner_channel: synchronizer, debouncer, edge and repeat logic for a single bit.
  - Instantiated WIDTH times by generate.
  - The tick generator stays in the top level.

## Test plan

Bench parameters: SAMPLE_COUNT_MAX=4, PULSE_COUNT_MAX=3, SYNC_STAGES=2, REPEAT_DELAY=5, REPEAT_PERIOD=2, WIDTH=3.

- Reset: reset_b=0 with in=3'b111 → level/press/release=0. Release reset, hold in → level=3'b111 within 2+12 cycles, with a single press=3'b111 pulse.
- Clean step on in[0], held 40 cycles, then dropped → one press and one release. Each is coincident with the level change, 11–14 cycles after the input edge.
- Glitch: in[1] high for 6 cycles, low for 1 cycle, high for 30 cycles → the glitch restarts debounce; exactly one press, no release.
- Simultaneous: in[0] rises while in[2] falls, both stable → press[0] and release[2] both assert, possibly in the same cycle; the other bits stay 0.
- Mid-operation reset: level[0]=1, pulse reset_b low for 1 cycle → level drops to 0 asynchronously with no release pulse. Holding in[0] high gives a fresh press.
- With INPUT_CONDITIONER_REPEAT_EN, hold in[0] for 60 cycles → press at the rising edge, repeat 5 ticks later, then every 2 ticks. Release stops the repeats.
- Without the macro, the same stimulus gives exactly one press.
